// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - select/OE sequencer that scans masked channels of a 4:1 tri-state mux
module mux_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic [1:0]         sel,
  output logic               oe,
  output logic               busy,
  output logic               done,
  output logic               sample_valid,
  output logic [1:0]         sample_chan,
  output logic               sample_bit,
  output logic [3:0]         frame
);

  typedef enum logic [2:0] {IDLE, SETTLE, DRIVE, SAMPLE, FINISH} state_t;

  state_t             state, state_nx;
  logic [3:0]         mask_q, mask_nx;
  logic [DWELL_W-1:0] dwell_q, dwell_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [1:0]         sel_nx, low_chan, next_chan;
  logic               more;
  logic               oe_nx, busy_nx, done_nx, sv_nx, sb_nx;
  logic [1:0]         sc_nx;
  logic [3:0]         frame_nx;

  // lowest requested channel of the incoming mask, used as the first channel of a pass
  always_comb begin
    low_chan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i]) low_chan = 2'(i);
    end
  end

  // next latched channel strictly above the one currently selected
  always_comb begin
    more      = 1'b0;
    next_chan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > sel)) begin
        more      = 1'b1;
        next_chan = 2'(i);
      end
    end
  end

  // next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nx = state;
    mask_nx  = mask_q;
    dwell_nx = dwell_q;
    cnt_nx   = cnt;
    sel_nx   = sel;
    frame_nx = frame;
    sv_nx    = 1'b0;
    sc_nx    = sample_chan;
    sb_nx    = sample_bit;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          frame_nx = 4'd0;
          if (chan_mask != 4'd0) begin
            mask_nx  = chan_mask;
            dwell_nx = dwell;
            sel_nx   = low_chan;
            state_nx = SETTLE;
          end else begin
            state_nx = FINISH;
          end
        end
      end
      SETTLE: begin
        cnt_nx   = dwell_q;
        state_nx = DRIVE;
      end
      DRIVE: begin
        if (cnt == '0) state_nx = SAMPLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      SAMPLE: begin
        frame_nx[sel] = y_in;
        sb_nx         = y_in;
        sc_nx         = sel;
        sv_nx         = 1'b1;
        if (more) begin
          sel_nx   = next_chan;
          state_nx = SETTLE;
        end else begin
          state_nx = FINISH;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a cancelled pass drops back to IDLE without recording the in-flight sample
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      sel_nx   = sel;
      frame_nx = frame;
      sv_nx    = 1'b0;
      sc_nx    = sample_chan;
      sb_nx    = sample_bit;
    end
    oe_nx   = (state_nx == DRIVE) || (state_nx == SAMPLE);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == FINISH);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= 4'd0;
      dwell_q      <= '0;
      cnt          <= '0;
      sel          <= 2'd0;
      oe           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_chan  <= 2'd0;
      sample_bit   <= 1'b0;
      frame        <= 4'd0;
    end else begin
      state        <= state_nx;
      mask_q       <= mask_nx;
      dwell_q      <= dwell_nx;
      cnt          <= cnt_nx;
      sel          <= sel_nx;
      oe           <= oe_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      sample_valid <= sv_nx;
      sample_chan  <= sc_nx;
      sample_bit   <= sb_nx;
      frame        <= frame_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] chan_mask;
  logic [3:0] dwell;
  logic       y_in;
  logic [1:0] sel;
  logic       oe, busy, done, sample_valid;
  logic [1:0] sample_chan;
  logic       sample_bit;
  logic [3:0] frame;
  logic [3:0] dbus;

  int compared   = 0;
  int mismatched = 0;

  // expected samples: {chan, bit}
  logic [2:0] sb_q[$];
  logic [1:0] last_sel;

  mux_scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .chan_mask(chan_mask), .dwell(dwell), .y_in(y_in),
    .sel(sel), .oe(oe), .busy(busy), .done(done),
    .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_bit(sample_bit), .frame(frame)
  );

  // behavioural tri-state mux
  assign y_in = oe ? dbus[sel] : 1'bz;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sample monitor: pops the scoreboard and guards select stability under OE
  logic       prev_oe = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  always @(posedge clk) begin
    #1;
    if (sample_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_sample", {29'd0, sample_chan, sample_bit}, 32'hFFFF);
      end else begin
        logic [2:0] e;
        e = sb_q.pop_front();
        check("sample_chan", sample_chan, e[2:1]);
        check("sample_bit", sample_bit, e[0]);
      end
    end
    if (prev_oe && oe) check("sel_stable_under_oe", sel, prev_sel);
    prev_oe  = oe;
    prev_sel = sel;
  end

  // full pass against a cycle-by-cycle schedule built from mask/dwell/d-bus
  task automatic run_pass(input logic [3:0] m, input logic [3:0] dw, input logic [3:0] d,
                          input bit disturb);
    logic [1:0] es[$];
    logic       eo[$];
    logic [1:0] cur;
    int n;
    cur = last_sel;
    dbus = d; chan_mask = m; dwell = dw;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        sb_q.push_back({2'(i), d[i]});
        es.push_back(2'(i)); eo.push_back(1'b0);
        for (int k = 0; k <= int'(dw) + 1; k++) begin
          es.push_back(2'(i)); eo.push_back(1'b1);
        end
        cur = 2'(i);
      end
    end
    es.push_back(cur); eo.push_back(1'b0);
    n = es.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("sel", sel, es[k]);
      check("oe", oe, eo[k]);
      check("busy", busy, 1'b1);
      check("done", done, (k == n - 1));
      if (k == n - 1) check("frame", frame, d & m);
      if (disturb && k == 2) begin
        start = 1'b1; chan_mask = ~m; dwell = dw + 4'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("busy_after_done", busy, 1'b0);
    check("done_after", done, 1'b0);
    check("scoreboard_empty", sb_q.size(), 0);
    last_sel = cur;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    chan_mask = 4'd0; dwell = 4'd0; dbus = 4'd0; last_sel = 2'd0;
    #12;
    check("rst_sel", sel, 2'd0);
    check("rst_oe", oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sv", sample_valid, 1'b0);
    check("rst_frame", frame, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // two-channel pass with dwell 2
    run_pass(4'b0101, 4'd2, 4'b0100, 1'b0);
    // empty mask: immediate done
    run_pass(4'b0000, 4'd3, 4'b1111, 1'b0);
    // all channels, zero dwell
    run_pass(4'b1111, 4'd0, 4'b1101, 1'b0);
    // start retrigger and mask/dwell change mid-pass ignored
    run_pass(4'b0101, 4'd2, 4'b0100, 1'b1);
    // maximum dwell
    run_pass(4'b1000, 4'd15, 4'b1000, 1'b0);

    // abort during second DRIVE of a two-channel pass
    dbus = 4'b0011; chan_mask = 4'b0011; dwell = 4'd3;
    sb_q.push_back({2'd0, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort_pre_sel", sel, 2'd1);
    check("abort_pre_oe", oe, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_oe", oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_frame", frame, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      check("abort_idle_done", done, 1'b0);
      check("abort_idle_oe", oe, 1'b0);
      tick();
    end
    check("abort_scoreboard", sb_q.size(), 0);

    // abort in IDLE beats start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_beats_start", busy, 1'b0);
    tick();

    // asynchronous reset during second DRIVE
    dbus = 4'b0011; chan_mask = 4'b1111; dwell = 4'd5;
    sb_q.push_back({2'd0, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("prerst_oe", oe, 1'b1);
    check("prerst_frame", frame, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("arst_oe", oe, 1'b0);
    check("arst_sel", sel, 2'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_frame", frame, 4'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_done", done, 1'b0);
      tick();
    end
    check("rst_scoreboard", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
